// File: rtl/mem_bus_responder.sv
// mem_bus_responder: two-region word memory on an Avalon-style bus with programmable wait states
module mem_bus_responder #(
    parameter string BOOT_INIT_FILE = "",
    parameter string DATA_INIT_FILE = "",
    parameter int    AW             = 10,
    parameter int    WAIT_CYCLES    = 1,
    parameter bit    RANDOM_WAIT    = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        bus_error
);
    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

    localparam logic [31:0] BOOT_BASE = 32'hBFC00000;
    localparam int          DEPTH     = 1 << AW;

    logic [31:0]   boot_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    state_t        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d, tgt_q, tgt_d, tgt_new;
    logic [15:0]   lfsr_q, lfsr_d, lfsr_next;
    logic [31:0]   readdata_q, readdata_d;
    logic          bus_error_q, bus_error_d;
    logic          req, boot_hit, data_hit, mapped, conflict, commit;
    logic [AW-1:0] idx;
    logic [31:0]   mem_word, rsp_word, wmask, merged;
    logic          unused_addr_bits;

    assign req      = read || write;
    assign conflict = read && write;
    assign boot_hit = address[31:AW+2] == BOOT_BASE[31:AW+2];
    assign data_hit = address[31:AW+2] == '0;
    assign mapped   = boot_hit || data_hit;
    assign idx      = address[AW+1:2];
    assign mem_word = boot_hit ? boot_mem[idx] : data_mem[idx];
    assign rsp_word = (conflict || !mapped) ? 32'h0 : mem_word;
    assign wmask    = {{8{byteenable[3]}}, {8{byteenable[2]}}, {8{byteenable[1]}}, {8{byteenable[0]}}};
    assign merged   = (mem_word & ~wmask) | (writedata & wmask);
    assign commit   = state_q == RESPOND && write && !read && mapped;
    // Fibonacci LFSR for x^16+x^14+x^13+x^11+1, shifting right
    assign lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign tgt_new   = 5'(WAIT_CYCLES) + (RANDOM_WAIT ? {3'b000, lfsr_q[1:0]} : 5'd0);

    assign waitrequest      = !reset || (req && state_q != RESPOND);
    assign readdata         = readdata_q;
    assign bus_error        = bus_error_q;
    assign unused_addr_bits = ^address[1:0];

    // cnt counts wait cycles including the IDLE cycle where the request first appears
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tgt_d       = tgt_q;
        lfsr_d      = lfsr_q;
        readdata_d  = readdata_q;
        bus_error_d = bus_error_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    tgt_d      = tgt_new;
                    cnt_d      = 5'd1;
                    state_d    = tgt_new == 5'd1 ? RESPOND : WAIT;
                    readdata_d = tgt_new == 5'd1 ? rsp_word : readdata_q;
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = 5'd0;
                end else if (cnt_q == tgt_q - 5'd1) begin
                    state_d    = RESPOND;
                    readdata_d = rsp_word;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            RESPOND: begin
                state_d     = IDLE;
                cnt_d       = 5'd0;
                lfsr_d      = req ? lfsr_next : lfsr_q;
                bus_error_d = bus_error_q || (req && (conflict || !mapped));
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state register; reset aborts any transfer in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            tgt_q       <= 5'd0;
            lfsr_q      <= 16'hACE1;
            readdata_q  <= 32'h0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tgt_q       <= tgt_d;
            lfsr_q      <= lfsr_d;
            readdata_q  <= readdata_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Commit writes at the edge that ends RESPOND; contents survive reset
    always_ff @(posedge clk) begin
        if (commit && boot_hit) boot_mem[idx] <= merged;
        if (commit && data_hit) data_mem[idx] <= merged;
    end
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: vector table, corner sequences and randomized model check of mem_bus_responder
module tb_mem_bus_responder;
    logic        clk = 1'b0;
    logic        rst_n [4];
    logic [31:0] addr [4];
    logic [31:0] wdata [4];
    logic [31:0] rdata [4];
    logic [3:0]  be [4];
    logic        rd [4];
    logic        wr [4];
    logic        wreq [4];
    logic        berr [4];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_bus_responder #(.WAIT_CYCLES(1)) u0 (
        .clk(clk), .reset(rst_n[0]), .address(addr[0]), .read(rd[0]), .write(wr[0]),
        .writedata(wdata[0]), .byteenable(be[0]), .waitrequest(wreq[0]), .readdata(rdata[0]), .bus_error(berr[0]));
    mem_bus_responder #(.WAIT_CYCLES(3)) u1 (
        .clk(clk), .reset(rst_n[1]), .address(addr[1]), .read(rd[1]), .write(wr[1]),
        .writedata(wdata[1]), .byteenable(be[1]), .waitrequest(wreq[1]), .readdata(rdata[1]), .bus_error(berr[1]));
    mem_bus_responder #(.WAIT_CYCLES(3), .RANDOM_WAIT(1'b1)) u2 (
        .clk(clk), .reset(rst_n[2]), .address(addr[2]), .read(rd[2]), .write(wr[2]),
        .writedata(wdata[2]), .byteenable(be[2]), .waitrequest(wreq[2]), .readdata(rdata[2]), .bus_error(berr[2]));
    mem_bus_responder #(.WAIT_CYCLES(4)) u3 (
        .clk(clk), .reset(rst_n[3]), .address(addr[3]), .read(rd[3]), .write(wr[3]),
        .writedata(wdata[3]), .byteenable(be[3]), .waitrequest(wreq[3]), .readdata(rdata[3]), .bus_error(berr[3]));

    typedef struct {
        bit          r;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        logic [31:0] q;
    } vec_t;

    vec_t tv [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Call at posedge+1 with the request already driven; returns at posedge+1 after completion
    task automatic wait_acc(input int s, output logic [31:0] q, output int waits);
        bit done = 0;
        waits = 0;
        q = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (wreq[s]) waits++;
            else begin
                q = rdata[s];
                done = 1;
            end
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout inst %0d: waitrequest still 1 required 0", s);
        end
        @(posedge clk);
        #1;
        rd[s] = 0;
        wr[s] = 0;
    endtask

    task automatic xfer(input int s, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] q, output int waits);
        addr[s] = a;
        wdata[s] = d;
        be[s] = b;
        rd[s] = r;
        wr[s] = w;
        wait_acc(s, q, waits);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] fb;
        fb = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 16'h1;
        return (v >> 1) | (fb << 15);
    endfunction

    function automatic logic [31:0] laddr(input int i);
        return i < 8 ? 32'(i * 4) : 32'hBFC00000 + 32'((i - 8) * 4);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] q, m_lfsr, mask;
        logic [31:0] mm [12];
        int w, seen;
        bit m_err;
        for (int s = 0; s < 4; s++) begin
            rst_n[s] = 0; rd[s] = 0; wr[s] = 0; addr[s] = '0; wdata[s] = '0; be[s] = '0;
        end
        tv[0]  = '{0, 1, 32'hBFC00000, 32'h8C030001, 4'hF, 32'h0};
        tv[1]  = '{1, 0, 32'hBFC00000, 32'h0,        4'hF, 32'h8C030001};
        tv[2]  = '{0, 1, 32'h00000004, 32'hDEADBEEF, 4'hF, 32'h0};
        tv[3]  = '{0, 1, 32'h00000004, 32'h000000AA, 4'h1, 32'h0};
        tv[4]  = '{1, 0, 32'h00000004, 32'h0,        4'h0, 32'hDEADBEAA};
        tv[5]  = '{0, 1, 32'h00000008, 32'h12345678, 4'hF, 32'h0};
        tv[6]  = '{1, 0, 32'h00000008, 32'h0,        4'hF, 32'h12345678};
        tv[7]  = '{0, 1, 32'hBFC00FFC, 32'hCAFEF00D, 4'hF, 32'h0};
        tv[8]  = '{0, 1, 32'hBFC00FFC, 32'h0000BB00, 4'h2, 32'h0};
        tv[9]  = '{1, 0, 32'hBFC00FFE, 32'h0,        4'h1, 32'hCAFEBB0D};
        tv[10] = '{0, 1, 32'h00000FFC, 32'h0BADC0DE, 4'hF, 32'h0};
        tv[11] = '{0, 1, 32'h00000FFC, 32'h11000000, 4'h8, 32'h0};
        tv[12] = '{1, 0, 32'h00000FFC, 32'h0,        4'hF, 32'h11ADC0DE};
        tv[13] = '{0, 1, 32'h00000004, 32'hFFFFFFFF, 4'h0, 32'h0};
        tv[14] = '{1, 0, 32'h00000004, 32'h0,        4'hF, 32'hDEADBEAA};

        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("rst_waitreq%0d", s), 32'(wreq[s]), 32'h1);
            chk($sformatf("rst_readdata%0d", s), rdata[s], 32'h0);
            chk($sformatf("rst_buserr%0d", s), 32'(berr[s]), 32'h0);
        end
        @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) rst_n[s] = 1;

        for (int i = 0; i < 15; i++) begin
            xfer(0, tv[i].r, tv[i].w, tv[i].a, tv[i].d, tv[i].b, q, w);
            chk($sformatf("vec%0d_waits", i), 32'(w), 32'd1);
            chk($sformatf("vec%0d_buserr", i), 32'(berr[0]), 32'h0);
            if (tv[i].r) chk($sformatf("vec%0d_rdata", i), q, tv[i].q);
        end

        xfer(0, 1, 1, 32'h8, 32'hFFFFFFFF, 4'hF, q, w);
        chk("both_rdata", q, 32'h0);
        chk("both_waits", 32'(w), 32'd1);
        chk("both_buserr", 32'(berr[0]), 32'h1);
        xfer(0, 1, 0, 32'h8, 32'h0, 4'hF, q, w);
        chk("both_mem_kept", q, 32'h12345678);
        chk("both_err_sticky", 32'(berr[0]), 32'h1);

        xfer(1, 0, 1, 32'h10, 32'hA5A5A5A5, 4'hF, q, w);
        chk("w3_write_waits", 32'(w), 32'd3);
        xfer(1, 1, 0, 32'h10, 32'h0, 4'hF, q, w);
        chk("w3_read_waits", 32'(w), 32'd3);
        chk("w3_rdata", q, 32'hA5A5A5A5);
        chk("w3_err_clear", 32'(berr[1]), 32'h0);
        xfer(1, 0, 1, 32'h0, 32'h01020304, 4'hF, q, w);
        xfer(1, 0, 1, 32'hBFC00000, 32'h0A0B0C0D, 4'hF, q, w);
        xfer(1, 1, 0, 32'h40000000, 32'h0, 4'hF, q, w);
        chk("unmapped_rdata", q, 32'h0);
        chk("unmapped_waits", 32'(w), 32'd3);
        chk("unmapped_buserr", 32'(berr[1]), 32'h1);
        xfer(1, 1, 0, 32'hBFBFFFFC, 32'h0, 4'hF, q, w);
        chk("below_boot_rdata", q, 32'h0);
        xfer(1, 0, 1, 32'h00001000, 32'hFFFFFFFF, 4'hF, q, w);
        xfer(1, 0, 1, 32'hBFC01000, 32'hFFFFFFFF, 4'hF, q, w);
        xfer(1, 1, 0, 32'h0, 32'h0, 4'hF, q, w);
        chk("past_data_discard", q, 32'h01020304);
        xfer(1, 1, 0, 32'hBFC00000, 32'h0, 4'hF, q, w);
        chk("past_boot_discard", q, 32'h0A0B0C0D);
        chk("err_sticky_good", 32'(berr[1]), 32'h1);
        rst_n[1] = 0;
        @(negedge clk);
        chk("pulse_waitreq", 32'(wreq[1]), 32'h1);
        chk("pulse_buserr", 32'(berr[1]), 32'h0);
        chk("pulse_rdata", rdata[1], 32'h0);
        @(posedge clk);
        #1;
        rst_n[1] = 1;
        xfer(1, 1, 0, 32'h10, 32'h0, 4'hF, q, w);
        chk("mem_survives_reset", q, 32'hA5A5A5A5);
        chk("err_after_reset", 32'(berr[1]), 32'h0);

        xfer(3, 0, 1, 32'hC, 32'h11223344, 4'hF, q, w);
        chk("w4_waits", 32'(w), 32'd4);
        addr[3] = 32'hC; wdata[3] = 32'h55555555; be[3] = 4'hF; wr[3] = 1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n[3] = 0;
        wr[3] = 0;
        #1;
        chk("abort_waitreq", 32'(wreq[3]), 32'h1);
        @(posedge clk);
        #1;
        rst_n[3] = 1;
        xfer(3, 1, 0, 32'hC, 32'h0, 4'hF, q, w);
        chk("abort_no_commit", q, 32'h11223344);
        addr[3] = 32'hC; rd[3] = 1;
        @(negedge clk);
        @(negedge clk);
        rst_n[3] = 0;
        #1;
        chk("held_rst_waitreq", 32'(wreq[3]), 32'h1);
        @(posedge clk);
        #1;
        rst_n[3] = 1;
        wait_acc(3, q, w);
        chk("held_restart_waits", 32'(w), 32'd4);
        chk("held_restart_rdata", q, 32'h11223344);

        m_lfsr = 32'hACE1;
        m_err = 0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            mm[i] = $urandom;
            xfer(2, 0, 1, laddr(i), mm[i], 4'hF, q, w);
            chk($sformatf("rinit%0d_waits", i), 32'(w), 3 + (m_lfsr & 3));
            seen |= 1 << w;
            m_lfsr = 32'(lfsr_step(m_lfsr[15:0]));
        end
        addr[2] = laddr(3); rd[2] = 1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rd[2] = 0;
        @(posedge clk);
        #1;
        for (int n = 0; n < 200; n++) begin
            int k = $urandom_range(0, 11);
            int op = $urandom_range(0, 15);
            logic [31:0] d = $urandom;
            logic [3:0] b = 4'($urandom_range(0, 15));
            if (op < 4) begin
                xfer(2, 0, 1, laddr(k), d, b, q, w);
                mask = 0;
                for (int j = 0; j < 4; j++) if (b[j]) mask |= 32'hFF << (8 * j);
                mm[k] = (mm[k] & ~mask) | (d & mask);
            end else if (op == 15) begin
                xfer(2, 1, 0, 32'h20000000, 32'h0, 4'hF, q, w);
                chk($sformatf("rnd%0d_unmapped", n), q, 32'h0);
                m_err = 1;
            end else begin
                xfer(2, 1, 0, laddr(k), 32'h0, b, q, w);
                chk($sformatf("rnd%0d_rdata", n), q, mm[k]);
            end
            chk($sformatf("rnd%0d_waits", n), 32'(w), 3 + (m_lfsr & 3));
            chk($sformatf("rnd%0d_buserr", n), 32'(berr[2]), 32'(m_err));
            seen |= 1 << w;
            m_lfsr = 32'(lfsr_step(m_lfsr[15:0]));
        end
        chk("distinct_wait_counts", 32'($countones(seen) >= 2), 32'h1);
        chk("wait_range", 32'(seen & ~32'h78), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
